// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter between two word requesters sharing a
// byte-serial memory. Each granted word is moved as BEATS big-endian byte
// beats. Read bytes return RD_LAT cycles after their beat. The requester then
// gets a one-cycle acknowledge, and for reads the assembled word.
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int BEATS  = 4,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [ADDR_W-1:0]    addr0,
  input  logic [8*BEATS-1:0]   wdata0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [ADDR_W-1:0]    addr1,
  input  logic [8*BEATS-1:0]   wdata1,
  output logic                 ack1,
  output logic [8*BEATS-1:0]   rdata,
  output logic                 busy,
  output logic                 mem_req,
  output logic                 mem_rw_select,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [7:0]           mem_data_in,
  input  logic [7:0]           mem_data_out
);

  localparam int W  = 8 * BEATS;
  localparam int CW = $clog2(BEATS + RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, BEAT, DRAIN, DONE} state_t;

  state_t              state, next_state;
  logic [CW-1:0]       cnt;
  logic                start, grant_id;
  logic                id_l, we_l, last_grant;
  logic [ADDR_W-1:0]   addr_l;
  logic [W-1:0]        wdata_l, shift_word, rdata_r, wr_shifted;
  logic [RD_LAT-1:0]   pipe_vld, pipe_last;
  logic                rd_issue, rd_issue_last;

  // Arbitration and sequencing: pick a winner in IDLE, walk beats, drain reads.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    grant_id   = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          start      = 1'b1;
          next_state = BEAT;
          if (req0 && req1) grant_id = ~last_grant;
          else              grant_id = req1;
        end
      end
      BEAT: begin
        if (cnt == CW'(BEATS - 1)) next_state = we_l ? DONE : DRAIN;
      end
      DRAIN: begin
        if (cnt == CW'(RD_LAT - 1)) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register plus the beat/drain counter, restarted on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (next_state != state) cnt <= '0;
      else if (state != IDLE)  cnt <= cnt + 1'b1;
    end
  end

  // Capture the winner's operands at the granting edge; later changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_l       <= 1'b0;
      we_l       <= 1'b0;
      addr_l     <= '0;
      wdata_l    <= '0;
      last_grant <= 1'b1;
    end else if (start) begin
      id_l       <= grant_id;
      we_l       <= grant_id ? we1 : we0;
      addr_l     <= grant_id ? addr1 : addr0;
      wdata_l    <= grant_id ? wdata1 : wdata0;
      last_grant <= grant_id;
    end
  end

  assign rd_issue      = (state == BEAT) && !we_l;
  assign rd_issue_last = rd_issue && (cnt == CW'(BEATS - 1));

  // Delay line marking which cycles carry a returning read byte, and the final one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld[0]  <= rd_issue;
      pipe_last[0] <= rd_issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  // Shift returning bytes in MSB first; publish the word when the last byte lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_word <= '0;
      rdata_r    <= '0;
    end else begin
      if (pipe_vld[RD_LAT-1]) shift_word <= W'({shift_word, mem_data_out});
      if (pipe_last[RD_LAT-1]) rdata_r <= W'({shift_word, mem_data_out});
    end
  end

  // Write byte for the current beat: beat k carries the k-th byte from the top.
  always_comb begin
    wr_shifted  = wdata_l << (8 * cnt);
    mem_data_in = 8'h00;
    if (state == BEAT && we_l) mem_data_in = wr_shifted[W-1 -: 8];
  end

  assign mem_req       = (state == BEAT);
  assign mem_rw_select = (state == BEAT) ? ~we_l : 1'b1;
  assign mem_address   = addr_l;
  assign busy          = (state != IDLE);
  assign ack0          = (state == DONE) && !id_l;
  assign ack1          = (state == DONE) && id_l;
  assign rdata         = rdata_r;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the byte-serial 32-bit-word memory between two requesters, e.g. port 0 for instruction fetch and port 1 for load/store.
- Each requester presents a whole-word read or write.
- The block sequences the four byte beats on the memory's 8-bit data path and returns the assembled word with a one-cycle acknowledge.
- Sits between the core's fetch and data stages and the memory.

Parameters:
- ADDR_W, 8: word address width, shared by the requesters and mem_address.
- BEATS, 4: byte beats per word. Word width is 8*BEATS.
- RD_LAT, 1: cycles from a read beat being issued to its byte appearing on mem_data_out.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req0  in  1  port 0 request; held high with stable operands until ack0
- we0  in  1  port 0 operation: 1 = write, 0 = read
- addr0  in  ADDR_W  port 0 word address
- wdata0  in  8*BEATS  port 0 write word
- ack0  out  1  one-cycle pulse: port 0 transaction complete
- req1, we1, addr1, wdata1, ack1: same as port 0, for port 1
- rdata  out  8*BEATS  assembled read word; valid in the ack cycle of a read
- busy  out  1  high whenever the FSM is not in IDLE
- mem_req  out  1  high during each beat cycle
- mem_rw_select  out  1  0 = write, 1 = read (memory encoding)
- mem_address  out  ADDR_W  word address, stable across all beats
- mem_data_in  out  8  write byte for the current beat
- mem_data_out  in  8  read byte from memory

Behaviour:
- Reset values (asynchronous): ack0=ack1=0, rdata=0, busy=0, mem_req=0, mem_rw_select=1, mem_address=0, mem_data_in=0. FSM goes to IDLE and beat counter to 0. The last-grant pointer goes to 1, so port 0 wins the first tie.
- FSM states: IDLE, BEAT, DRAIN, DONE.
- IDLE:
  - Samples req0/req1 in IDLE only.
  - One request pending: grant it.
  - Both pending: grant the port not granted last (round-robin).
  - At the granting edge, latch the winner id, we, addr and wdata, update the pointer, and go to BEAT.
- BEAT, for BEATS cycles with counter k = 0..BEATS-1:
  - mem_req=1, mem_rw_select=~we_latched, mem_address=addr_latched.
  - Byte order is big-endian: beat k carries bits [8*(BEATS-k)-1 : 8*(BEATS-k-1)], so beat 0 is the MSB.
  - Writes: mem_data_in = the byte for beat k.
  - Reads: the byte for beat k is captured from mem_data_out RD_LAT cycles after beat k's cycle.
- After the last beat:
  - Write: go straight to DONE.
  - Read: go to DRAIN for RD_LAT cycles (mem_req=0) to capture the trailing bytes, then DONE.
- DONE:
  - One cycle. Pulse the ack of the latched id.
  - For reads, rdata holds the full word. rdata keeps its value until the next read completes; writes do not change it.
  - Return to IDLE.
- Latency from a req sampled in IDLE at cycle t, with default parameters:
  - Write: beats at t+1..t+4, ack at t+5.
  - Read: beats at t+1..t+4, drain at t+5, ack at t+6.
  - IDLE is at t+6 after a write and at t+7 after a read. Minimum gap between grants is 6 cycles (write) or 7 cycles (read).
- Requesters must drop req, or present a new request, in the cycle after ack. A req still high when the FSM reaches IDLE is treated as a new transaction.
- Requests that arrive while busy are ignored until IDLE. The losing port waits with req held and is guaranteed the next grant.
- Operand changes on a granted port after the latching edge have no effect.
- mem_req is never high outside BEAT. mem_data_in is 0 outside write beats.
- Reset in mid-transaction: the transaction is abandoned with no ack, and outputs return to reset values. Beats already issued for a write may have modified memory; the requester must reissue.
- ack0 and ack1 are never high in the same cycle.

Test Plan:
- Single write: port 0 writes wdata0=32'hDEADBEEF to addr0=8'h10 -> mem_data_in is DE, AD, BE, EF on 4 consecutive mem_req cycles with mem_rw_select=0 and mem_address=10. ack0 pulses 5 cycles after req is sampled.
- Read-back: port 1 reads addr1=8'h10 -> 4 read beats, ack1 at +6 cycles, rdata=32'hDEADBEEF in the ack cycle. rdata is unchanged afterwards.
- Simultaneous requests from reset: both ports request reads of 8'h00 and 8'h01 in the same cycle -> port 0 is served first, then port 1. Repeating the tie with both held -> ports alternate 1, 0.
- Held request: port 0 keeps req0 high after ack0 while port 1 is idle -> port 0 is re-granted on the next IDLE cycle and gets exactly one ack per transaction.
- Mid-operation reset: reset asserted during beat 2 of a read -> outputs go to reset values immediately, no ack is generated. After release, a new request completes normally.
- Stability: during every transaction, mem_address and mem_rw_select stay constant across all beats, and mem_req is never high outside the beats.
